dm_port_ctrl: RTL and testbench

Access controller placed in front of the single-port data memory (4096 × 32-bit, word-indexed by address bits [13:2], combinational read, write on rising clock edge). It shares the memory between the CPU data port and a debug/loader port using round-robin arbitration. It also sequences a zero-fill sweep, one word per cycle, after reset and on request, so the memory itself does not need a single-cycle bulk clear.

---
 rtl/dm_port_ctrl_pkg.sv | 16 +
 rtl/dm_port_ctrl_rr_arb2.sv | 18 +
 rtl/dm_port_ctrl.sv | 136 +++++++++++++
 tb/tb_dm_port_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dm_port_ctrl_pkg.sv
// Shared definitions for the data-memory port controller: state encoding,
// port identifiers and the default memory geometry.
package dm_port_ctrl_pkg;

    localparam int DEPTH_DEF = 4096;
    localparam int IDX_W_DEF = 12;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/dm_port_ctrl_rr_arb2.sv
// Two-requester round-robin pick: on a conflict the port that did not win
// most recently is granted; a lone requester always wins.
module rr_arb2
    import dm_port_ctrl_pkg::*;
(
    input  logic req_cpu,
    input  logic req_dbg,
    input  logic last,
    output logic gnt_cpu,
    output logic gnt_dbg
);

    always_comb begin
        gnt_cpu = req_cpu && (!req_dbg || (last == PORT_DBG));
        gnt_dbg = req_dbg && (!req_cpu || (last == PORT_CPU));
    end

endmodule

// File: rtl/dm_port_ctrl.sv
// Shares the single-port data memory between the CPU and debug ports and
// sequences a one-word-per-cycle zero-fill sweep after reset or on request.
module dm_port_ctrl
    import dm_port_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [31:0] cpu_pc,
    output logic        cpu_gnt,
    output logic [31:0] cpu_rdata,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic [31:0] dbg_rdata,
    input  logic        clr_start,
    output logic        busy,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_pc,
    output logic        mem_clr,
    input  logic [31:0] mem_rdata
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;
    logic               last_q, last_d;
    logic               arb_cpu, arb_dbg;

    // Only the word-index bits reach the memory; the rest are dropped so
    // addresses wrap modulo DEPTH.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[31:IDX_W+2], cpu_addr[1:0],
                                dbg_addr[31:IDX_W+2], dbg_addr[1:0]};

    function automatic logic [31:0] word_addr(input logic [IDX_W-1:0] idx);
        logic [31:0] r;
        r = '0;
        r[IDX_W+1:2] = idx;
        return r;
    endfunction

    rr_arb2 u_arb (
        .req_cpu (cpu_req),
        .req_dbg (dbg_req),
        .last    (last_q),
        .gnt_cpu (arb_cpu),
        .gnt_dbg (arb_dbg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
            last_q    <= PORT_DBG;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            last_q    <= last_d;
        end
    end

    // Outputs are held quiet (busy excepted) while reset is high so no
    // sweep write escapes before the first edge after release.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        last_d    = last_q;
        cpu_gnt   = 1'b0;
        dbg_gnt   = 1'b0;
        cpu_rdata = '0;
        dbg_rdata = '0;
        busy      = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_pc    = '0;
        mem_clr   = 1'b0;

        if (reset) begin
            busy = 1'b1;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    busy      = 1'b1;
                    mem_we    = 1'b1;
                    mem_clr   = 1'b1;
                    mem_addr  = word_addr(clr_idx_q);
                    clr_idx_d = clr_idx_q + 1'b1;
                    if (clr_idx_q == LAST_IDX) begin
                        clr_idx_d = '0;
                        state_d   = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (clr_start) begin
                        state_d   = ST_CLEAR;
                        clr_idx_d = '0;
                    end else begin
                        cpu_rdata = mem_rdata;
                        dbg_rdata = mem_rdata;
                        cpu_gnt   = arb_cpu;
                        dbg_gnt   = arb_dbg;
                        if (arb_cpu) begin
                            mem_we    = cpu_we;
                            mem_addr  = word_addr(cpu_addr[IDX_W+1:2]);
                            mem_wdata = cpu_wdata;
                            mem_pc    = cpu_we ? cpu_pc : 32'h0;
                            last_d    = PORT_CPU;
                        end else if (arb_dbg) begin
                            mem_we    = dbg_we;
                            mem_addr  = word_addr(dbg_addr[IDX_W+1:2]);
                            mem_wdata = dbg_wdata;
                            last_d    = PORT_DBG;
                        end
                    end
                end
                default: begin
                    state_d = ST_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_port_ctrl.sv
// Scoreboard bench for dm_port_ctrl: directed accesses push expected grants,
// a negedge monitor pops and compares; sweeps are checked beat by beat.
module tb_dm_port_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dbg_req, dbg_we, clr_start;
    logic [31:0] cpu_addr, cpu_wdata, cpu_pc, dbg_addr, dbg_wdata;
    logic        cpu_gnt, dbg_gnt, busy, mem_we, mem_clr;
    logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_pc, mem_rdata;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];

    logic [31:0] mem [4096];

    always #5 clk = ~clk;

    dm_port_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_pc    (cpu_pc),
        .cpu_gnt   (cpu_gnt),
        .cpu_rdata (cpu_rdata),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_gnt   (dbg_gnt),
        .dbg_rdata (dbg_rdata),
        .clr_start (clr_start),
        .busy      (busy),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_pc    (mem_pc),
        .mem_clr   (mem_clr),
        .mem_rdata (mem_rdata)
    );

    // Memory model: combinational read, write on rising edge, nonzero fill
    // so the zero-fill sweep is observable.
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
    end
    always @(posedge clk) if (mem_we) mem[mem_addr[13:2]] <= mem_wdata;
    assign mem_rdata = mem[mem_addr[13:2]];

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic void pushExp(input string name, input logic port,
                                    input logic we, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [31:0] pc,
                                    input logic [31:0] rdata);
        exp_t e;
        e.name = name; e.port = port; e.we = we; e.addr = addr;
        e.wdata = wdata; e.pc = pc; e.rdata = rdata;
        sb.push_back(e);
    endfunction

    task automatic applyStimulus(input logic cr, input logic cw, input logic [31:0] ca,
                                 input logic [31:0] cd, input logic [31:0] cp,
                                 input logic dr, input logic dw, input logic [31:0] da,
                                 input logic [31:0] dd, input logic clr);
        @(posedge clk);
        #1;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd; cpu_pc = cp;
        dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd; clr_start = clr;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic runSweep(input string name);
        int cyc;
        int bad;
        logic [31:0] ea;
        cyc = 0;
        bad = 0;
        @(negedge clk);
        while (busy === 1'b1 && cyc < 5000) begin
            ea = 32'(cyc) << 2;
            if (mem_addr !== ea || mem_we !== 1'b1 || mem_clr !== 1'b1 ||
                mem_wdata !== 32'h0 || mem_pc !== 32'h0 ||
                cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0)
                bad++;
            cyc++;
            @(negedge clk);
        end
        checkOutput({name, " busy cycles"}, 32'(cyc), 32'd4096);
        checkOutput({name, " bad beats"}, 32'(bad), 32'd0);
    endtask

    // Monitor: every granted cycle must match the oldest expected access.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cpu_gnt === 1'b1 || dbg_gnt === 1'b1) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected grant", {30'b0, dbg_gnt, cpu_gnt}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    checkOutput({e.name, " grants"}, {30'b0, dbg_gnt, cpu_gnt},
                                e.port ? 32'h2 : 32'h1);
                    checkOutput({e.name, " mem_we"}, 32'(mem_we), 32'(e.we));
                    checkOutput({e.name, " mem_addr"}, mem_addr, e.addr);
                    checkOutput({e.name, " mem_clr"}, 32'(mem_clr), 32'h0);
                    checkOutput({e.name, " mem_pc"}, mem_pc, e.pc);
                    if (e.we)
                        checkOutput({e.name, " mem_wdata"}, mem_wdata, e.wdata);
                    else
                        checkOutput({e.name, " rdata"}, e.port ? dbg_rdata : cpu_rdata,
                                    e.rdata);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_pc = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; clr_start = 0;
        repeat (2) @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'h1);
        checkOutput("reset mem_we", 32'(mem_we), 32'h0);
        checkOutput("reset mem_addr", mem_addr, 32'h0);
        checkOutput("reset grants", {30'b0, dbg_gnt, cpu_gnt}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        runSweep("sweep0");

        pushExp("cpu_wr", 0, 1, 32'h10, 32'hDEADBEEF, 32'h3000, 0);
        applyStimulus(1, 1, 32'h10, 32'hDEADBEEF, 32'h3000, 0, 0, 0, 0, 0);
        pushExp("cpu_rd", 0, 0, 32'h10, 0, 0, 32'hDEADBEEF);
        applyStimulus(1, 0, 32'h10, 0, 32'h3000, 0, 0, 0, 0, 0);
        pushExp("dbg_wr_wrap", 1, 1, 32'h10, 32'h12345678, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h4010, 32'h12345678, 0);
        pushExp("cpu_rd_wrap", 0, 0, 32'h10, 0, 0, 32'h12345678);
        applyStimulus(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
        pushExp("dbg_wr_top", 1, 1, 32'h3FFC, 32'hCAFEF00D, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'hFFFF_FFFC, 32'hCAFEF00D, 0);
        pushExp("cpu_rd_top", 0, 0, 32'h3FFC, 0, 0, 32'hCAFEF00D);
        applyStimulus(1, 0, 32'h3FFC, 0, 0, 0, 0, 0, 0, 0);
        pushExp("dbg_rd_zero", 1, 0, 32'h20, 0, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h20, 0, 0);

        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) pushExp($sformatf("both%0d", i), 0, 0, 32'h10, 0, 0, 32'h12345678);
            else            pushExp($sformatf("both%0d", i), 1, 0, 32'h3FFC, 0, 0, 32'hCAFEF00D);
            applyStimulus(1, 0, 32'h10, 0, 0, 1, 0, 32'h3FFC, 0, 0);
        end
        idle();

        pushExp("after_clr_rd", 0, 0, 32'h10, 0, 0, 32'h0);
        applyStimulus(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        checkOutput("clr cycle grants", {30'b0, dbg_gnt, cpu_gnt}, 32'h0);
        checkOutput("clr cycle mem_we", 32'(mem_we), 32'h0);
        @(posedge clk);
        #1 clr_start = 1'b0;
        runSweep("sweep1");
        idle();

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #1 clr_start = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        checkOutput("idx100 mem_addr", mem_addr, 32'h190);
        reset = 1'b1;
        #1;
        checkOutput("midreset busy", 32'(busy), 32'h1);
        checkOutput("midreset mem_we", 32'(mem_we), 32'h0);
        checkOutput("midreset mem_addr", mem_addr, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        runSweep("sweep2");

        pushExp("final_rd", 0, 0, 32'h3FFC, 0, 0, 32'h0);
        applyStimulus(1, 0, 32'h3FFC, 0, 0, 0, 0, 0, 0, 0);
        idle();
        repeat (3) @(negedge clk);
        checkOutput("scoreboard drained", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
